// File: rtl/sr_chk_pkg.sv
// Shared types for the SR flip-flop response checker: FSM states and the {s,r} command code.
package sr_chk_pkg;

    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        TRACK   = 2'd1,
        FAULT   = 2'd2
    } chk_state_e;

    typedef enum logic [1:0] {
        HOLD    = 2'b00,
        RESET   = 2'b01,
        SET     = 2'b10,
        ILLEGAL = 2'b11
    } sr_cmd_e;

    function automatic sr_cmd_e decode_cmd(input logic s, input logic r);
        return sr_cmd_e'({s, r});
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/sr_ff_checker.sv
// Response checker for an SR flip-flop: tracks the expected q, flags mismatches and s=r=1
// requests, and keeps saturating error statistics.
module sr_ff_checker
    import sr_chk_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             q_bar,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             mismatch,
    output logic             illegal,
    output logic             fault,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] ill_cnt,
    output logic [CNT_W-1:0] first_err_cyc,
    output logic [CNT_W-1:0] cyc_cnt
);

    chk_state_e       state_q, state_d;
    logic             exp_q_q, exp_q_d;
    logic             exp_valid_q, exp_valid_d;
    logic             mismatch_q, illegal_q;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] first_q, first_d;
    sr_cmd_e          cmd;
    logic             active;
    logic             mm_det;
    logic             ill_det;

    assign cmd     = decode_cmd(s, r);
    assign active  = en && (state_q != FAULT);
    // q is judged against the model registered at the previous edge, hence state_q/exp_q_q.
    assign mm_det  = active && (state_q == TRACK) && ((q != exp_q_q) || (q_bar == q));
    assign ill_det = active && (cmd == ILLEGAL);

    always_comb begin
        state_d     = state_q;
        exp_q_d     = exp_q_q;
        exp_valid_d = exp_valid_q;
        fault_d     = fault_q | mm_det;
        first_d     = first_q;
        if (mm_det && !fault_q) begin
            first_d = cyc_cnt;
        end
        if (active) begin
            unique case (cmd)
                SET: begin
                    exp_q_d     = 1'b1;
                    exp_valid_d = 1'b1;
                    state_d     = TRACK;
                end
                RESET: begin
                    exp_q_d     = 1'b0;
                    exp_valid_d = 1'b1;
                    state_d     = TRACK;
                end
                ILLEGAL: begin
                    exp_valid_d = 1'b0;
                    state_d     = UNKNOWN;
                end
                default: ;
            endcase
        end
        if (mm_det && STOP_ON_ERR) begin
            state_d = FAULT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= UNKNOWN;
            exp_q_q     <= 1'b0;
            exp_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            illegal_q   <= 1'b0;
            fault_q     <= 1'b0;
            first_q     <= '0;
        end else begin
            state_q     <= state_d;
            exp_q_q     <= exp_q_d;
            exp_valid_q <= exp_valid_d;
            mismatch_q  <= mm_det;
            illegal_q   <= ill_det;
            fault_q     <= fault_d;
            first_q     <= first_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (mm_det),
        .cnt (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_ill_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ill_det),
        .cnt (ill_cnt)
    );

    sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk (clk),
        .rst (rst),
        .inc (en),
        .cnt (cyc_cnt)
    );

    assign exp_q         = exp_q_q;
    assign exp_valid     = exp_valid_q;
    assign mismatch      = mismatch_q;
    assign illegal       = illegal_q;
    assign fault         = fault_q;
    assign first_err_cyc = first_q;

endmodule

// File: tb/tb_sr_ff_checker.sv
// Bench for sr_ff_checker: two instances (8-bit free-running, 2-bit stop-on-error) share stimulus
// and are compared every cycle against an abstract model of the checking rules.
module tb_sr_ff_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic s   = 1'b0;
    logic r   = 1'b0;
    logic q   = 1'b0;
    logic q_bar = 1'b1;

    logic       a_exp_q, a_exp_valid, a_mismatch, a_illegal, a_fault;
    logic [7:0] a_err_cnt, a_ill_cnt, a_first_err_cyc, a_cyc_cnt;
    logic       b_exp_q, b_exp_valid, b_mismatch, b_illegal, b_fault;
    logic [1:0] b_err_cnt, b_ill_cnt, b_first_err_cyc, b_cyc_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sr_ff_checker #(.CNT_W(8), .STOP_ON_ERR(1'b0)) dut_a (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .s             (s),
        .r             (r),
        .q             (q),
        .q_bar         (q_bar),
        .exp_q         (a_exp_q),
        .exp_valid     (a_exp_valid),
        .mismatch      (a_mismatch),
        .illegal       (a_illegal),
        .fault         (a_fault),
        .err_cnt       (a_err_cnt),
        .ill_cnt       (a_ill_cnt),
        .first_err_cyc (a_first_err_cyc),
        .cyc_cnt       (a_cyc_cnt)
    );

    sr_ff_checker #(.CNT_W(2), .STOP_ON_ERR(1'b1)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .s             (s),
        .r             (r),
        .q             (q),
        .q_bar         (q_bar),
        .exp_q         (b_exp_q),
        .exp_valid     (b_exp_valid),
        .mismatch      (b_mismatch),
        .illegal       (b_illegal),
        .fault         (b_fault),
        .err_cnt       (b_err_cnt),
        .ill_cnt       (b_ill_cnt),
        .first_err_cyc (b_first_err_cyc),
        .cyc_cnt       (b_cyc_cnt)
    );

    typedef struct {
        int known;
        int stopped;
        int expq;
        int valid;
        int mm;
        int ill;
        int fault;
        int err;
        int illc;
        int first;
        int cyc;
    } model_t;

    model_t m_a = '{default: 0};
    model_t m_b = '{default: 0};

    function automatic int sat(input int x, input int maxv);
        return (x >= maxv) ? maxv : x + 1;
    endfunction

    function automatic model_t step(input model_t m, input int maxv, input bit stop,
                                    input bit rv, input bit ev, input bit sv, input bit rsv,
                                    input bit qv, input bit qbv);
        model_t n;
        bit     bad;
        n = m;
        if (rv) begin
            n = '{default: 0};
            return n;
        end
        n.mm  = 0;
        n.ill = 0;
        if (!ev) return n;
        n.cyc = sat(m.cyc, maxv);
        if (m.stopped != 0) return n;
        bad = (m.known != 0) && ((int'(qv) != m.expq) || (qbv == qv));
        if (bad) begin
            n.mm  = 1;
            n.err = sat(m.err, maxv);
            if (m.fault == 0) begin
                n.fault = 1;
                n.first = m.cyc;
            end
        end
        if (sv && rsv) begin
            n.ill   = 1;
            n.illc  = sat(m.illc, maxv);
            n.valid = 0;
            n.known = 0;
        end else if (sv || rsv) begin
            n.expq  = sv ? 1 : 0;
            n.valid = 1;
            n.known = 1;
        end
        if (bad && stop) n.stopped = 1;
        return n;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic cmp_all();
        check("a.exp_q", int'(a_exp_q), m_a.expq);
        check("a.exp_valid", int'(a_exp_valid), m_a.valid);
        check("a.mismatch", int'(a_mismatch), m_a.mm);
        check("a.illegal", int'(a_illegal), m_a.ill);
        check("a.fault", int'(a_fault), m_a.fault);
        check("a.err_cnt", int'(a_err_cnt), m_a.err);
        check("a.ill_cnt", int'(a_ill_cnt), m_a.illc);
        check("a.first_err_cyc", int'(a_first_err_cyc), m_a.first);
        check("a.cyc_cnt", int'(a_cyc_cnt), m_a.cyc);
        check("b.exp_q", int'(b_exp_q), m_b.expq);
        check("b.exp_valid", int'(b_exp_valid), m_b.valid);
        check("b.mismatch", int'(b_mismatch), m_b.mm);
        check("b.illegal", int'(b_illegal), m_b.ill);
        check("b.fault", int'(b_fault), m_b.fault);
        check("b.err_cnt", int'(b_err_cnt), m_b.err);
        check("b.ill_cnt", int'(b_ill_cnt), m_b.illc);
        check("b.first_err_cyc", int'(b_first_err_cyc), m_b.first);
        check("b.cyc_cnt", int'(b_cyc_cnt), m_b.cyc);
    endtask

    // Drive one cycle of stimulus, advance both models at the edge, then compare.
    task automatic apply(input bit rv, input bit ev, input bit sv, input bit rsv,
                         input bit qv, input bit qbv);
        @(negedge clk);
        rst   = rv;
        en    = ev;
        s     = sv;
        r     = rsv;
        q     = qv;
        q_bar = qbv;
        @(posedge clk);
        m_a = step(m_a, 255, 1'b0, rv, ev, sv, rsv, qv, qbv);
        m_b = step(m_b, 3, 1'b1, rv, ev, sv, rsv, qv, qbv);
        #1;
        cmp_all();
    endtask

    initial begin
        bit fq;
        bit sv, rsv, qv, qbv, ev, rv;
        int pick;

        // Reset, then SET into a correct flop
        apply(1, 1, 0, 0, 0, 1);
        check("rst.cyc_cnt", int'(a_cyc_cnt), 0);
        check("rst.exp_valid", int'(b_exp_valid), 0);
        apply(0, 1, 1, 0, 0, 1);
        check("set.exp_q", int'(a_exp_q), 1);
        check("set.exp_valid", int'(a_exp_valid), 1);
        apply(0, 1, 0, 0, 1, 0);
        check("set.mismatch", int'(a_mismatch), 0);
        check("set.err_cnt", int'(a_err_cnt), 0);

        // 00,10,01,00 into a correct flop
        apply(1, 1, 0, 0, 0, 1);
        apply(0, 1, 0, 0, 0, 1);
        check("seq.valid0", int'(a_exp_valid), 0);
        apply(0, 1, 1, 0, 0, 1);
        check("seq.exp1", int'(a_exp_q), 1);
        apply(0, 1, 0, 1, 1, 0);
        check("seq.exp2", int'(a_exp_q), 0);
        apply(0, 1, 0, 0, 0, 1);
        check("seq.exp3", int'(a_exp_q), 0);
        check("seq.cyc_cnt", int'(a_cyc_cnt), 4);
        check("seq.err_cnt", int'(a_err_cnt), 0);

        // Two illegal requests, then a bad q_bar is ignored until the model is re-established
        apply(0, 1, 1, 1, 0, 1);
        check("ill.pulse1", int'(a_illegal), 1);
        apply(0, 1, 1, 1, 0, 1);
        check("ill.pulse2", int'(a_illegal), 1);
        check("ill.ill_cnt", int'(a_ill_cnt), 2);
        check("ill.exp_valid", int'(a_exp_valid), 0);
        apply(0, 1, 0, 0, 1, 1);
        check("ill.ignored1", int'(a_mismatch), 0);
        apply(0, 1, 1, 0, 1, 1);
        check("ill.ignored2", int'(a_mismatch), 0);
        apply(0, 1, 0, 0, 1, 0);
        check("ill.good", int'(a_mismatch), 0);
        apply(0, 1, 0, 0, 1, 1);
        check("ill.qbar_bad", int'(a_mismatch), 1);

        // Saturation of the 2-bit illegal counter
        apply(1, 1, 0, 0, 0, 1);
        repeat (5) apply(0, 1, 1, 1, 0, 1);
        check("sat.b_ill_cnt", int'(b_ill_cnt), 3);
        check("sat.a_ill_cnt", int'(a_ill_cnt), 5);

        // Stop-on-error: forced q=0 after SET
        apply(1, 1, 0, 0, 0, 1);
        apply(0, 1, 1, 0, 0, 1);
        apply(0, 1, 0, 0, 0, 1);
        check("stop.mismatch", int'(b_mismatch), 1);
        check("stop.fault", int'(b_fault), 1);
        check("stop.err_cnt", int'(b_err_cnt), 1);
        check("stop.first_err", int'(b_first_err_cyc), 1);
        apply(0, 1, 0, 1, 0, 1);
        check("stop.ignored", int'(b_mismatch), 0);
        apply(0, 1, 0, 0, 1, 1);
        check("stop.err_held", int'(b_err_cnt), 1);
        check("stop.cyc_sat", int'(b_cyc_cnt), 3);

        // Reset while faulted
        apply(1, 1, 0, 0, 0, 1);
        check("rstf.fault", int'(b_fault), 0);
        check("rstf.err_cnt", int'(b_err_cnt), 0);
        check("rstf.first", int'(b_first_err_cyc), 0);
        check("rstf.cyc_cnt", int'(b_cyc_cnt), 0);
        check("rstf.a_fault", int'(a_fault), 0);
        apply(0, 1, 0, 0, 1, 1);
        check("rstf.unknown", int'(b_mismatch), 0);

        // Random traffic from a behavioural flop with occasional corrupted outputs
        fq = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            rv   = ($urandom_range(0, 59) == 0);
            ev   = ($urandom_range(0, 7) != 0);
            pick = int'($urandom_range(0, 7));
            sv   = (pick == 3) || (pick == 4) || (pick == 7);
            rsv  = (pick == 5) || (pick == 6) || (pick == 7);
            qv   = fq;
            qbv  = ~fq;
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 1) == 0) qv = ~qv;
                else qbv = ~qbv;
            end
            apply(rv, ev, sv, rsv, qv, qbv);
            if (sv && rsv) fq = bit'($urandom_range(0, 1));
            else if (sv) fq = 1'b1;
            else if (rsv) fq = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
